// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with pipeline stall and HI/LO result strobe.
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero skips the iterative divider and finishes in one cycle.
module muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quot;

   logic              accept;
   logic              in_sign_a;
   logic              in_sign_b;
   logic [XLEN-1:0]   in_mag_a;
   logic [XLEN-1:0]   in_mag_b;
   logic [2*XLEN-1:0] prod_mag;
   logic [2*XLEN-1:0] prod;
   logic [XLEN:0]     rem_sh;
   logic              q_bit;
   logic [XLEN-1:0]   rem_n;
   logic [XLEN-1:0]   quot_n;

   // Quotient takes the XOR of operand signs, remainder follows the dividend.
   function automatic logic [2*XLEN-1:0] div_fix(input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] q,
                                                 input logic            sa,
                                                 input logic            sb);
      logic [XLEN-1:0] r_f;
      logic [XLEN-1:0] q_f;
      r_f = sa ? (XLEN'(0) - r) : r;
      q_f = (sa ^ sb) ? (XLEN'(0) - q) : q;
      return {r_f, q_f};
   endfunction

   assign accept    = (state == S_IDLE) & start_i & ~flush_i;
   assign in_sign_a = ~op_i[0] & src_a_i[XLEN-1];
   assign in_sign_b = ~op_i[0] & src_b_i[XLEN-1];
   assign in_mag_a  = in_sign_a ? (XLEN'(0) - src_a_i) : src_a_i;
   assign in_mag_b  = in_sign_b ? (XLEN'(0) - src_b_i) : src_b_i;

   // Magnitude product, re-signed for MULT (sign flags are zero for MULTU).
   assign prod_mag = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
   assign prod     = (sign_a ^ sign_b) ? ((2*XLEN)'(0) - prod_mag) : prod_mag;

   // One restoring step: shift {rem, quot} left, subtract |b| if it fits.
   assign rem_sh = {rem, quot[XLEN-1]};
   assign q_bit  = (rem_sh >= {1'b0, mag_b});
   assign rem_n  = q_bit ? XLEN'(rem_sh - (XLEN+1)'(mag_b)) : rem_sh[XLEN-1:0];
   assign quot_n = {quot[XLEN-2:0], q_bit};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         cnt    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         rem    <= '0;
         quot   <= '0;
         hi_o   <= '0;
         lo_o   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  mag_a  <= in_mag_a;
                  mag_b  <= in_mag_b;
                  cnt    <= '0;
                  rem    <= '0;
                  quot   <= in_mag_a;
`ifdef MULDIV_DIV0_FAST_EN
                  // Zero divisor: the iterative result is known up front.
                  if (op_i[1] && (src_b_i == '0)) begin
                     state        <= S_DONE;
                     {hi_o, lo_o} <= div_fix(in_mag_a, '1, in_sign_a, in_sign_b);
                  end else begin
                     state <= op_i[1] ? S_DIV : S_MUL;
                  end
`else
                  state <= op_i[1] ? S_DIV : S_MUL;
`endif
               end
            end
            S_MUL: begin
               if (flush_i) begin
                  state <= S_IDLE;
               end else if (cnt == MUL_LAST) begin
                  state        <= S_DONE;
                  {hi_o, lo_o} <= prod;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DIV: begin
               if (flush_i) begin
                  state <= S_IDLE;
               end else begin
                  rem  <= rem_n;
                  quot <= quot_n;
                  cnt  <= cnt + CNT_W'(1);
                  if (cnt == DIV_LAST) begin
                     state        <= S_DONE;
                     {hi_o, lo_o} <= div_fix(rem_n, quot_n, sign_a, sign_b);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Stall covers the accepting cycle and all working cycles; DONE lets the pipeline advance.
   assign busy_o  = (state != S_IDLE);
   assign valid_o = resetn & (state == S_DONE) & ~flush_i;
   assign stall_o = resetn & ~flush_i &
                    (((state == S_IDLE) & start_i) | (state == S_MUL) | (state == S_DIV));

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU requests from the decoded instruction stream and runs a 32-step radix-2 restoring divider or a fixed-latency multiplier. It holds the pipeline with a stall while busy and delivers a 64-bit HI/LO result with a one-cycle valid for the HI/LO write port. A pipeline flush from exception handling aborts an in-flight operation.

## Interface
- `MUL_LAT`, default 2: cycles spent in MUL state (legal range 1..8).
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  EX-stage instruction is a mul/div op; held by the pipeline until `valid_o`.
- `op_i`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled on acceptance only.
- `src_a_i`  in  32  rs operand (dividend / multiplicand).
- `src_b_i`  in  32  rt operand (divisor / multiplier).
- `flush_i`  in  1  abort current operation and ignore `start_i` this cycle.
- `stall_o`  out  1  hold IF..EX stages.
- `busy_o`  out  1  state ≠ IDLE.
- `valid_o`  out  1  one-cycle strobe; `hi_o`/`lo_o` are to be written to HI/LO.
- `hi_o`  out  32  product[63:32] or remainder.
- `lo_o`  out  32  product[31:0] or quotient.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: `start_i & ~flush_i` accepts the request.
  - `op_i`, |a|, |b| and the sign flags are latched; signed ops take two's-complement magnitude.
  - Next state is MUL if `op_i[1]=0`, else DIV; the counter is cleared.
- MUL: the full product is computed from the latched operands (signed for MULT, unsigned for MULTU). After `MUL_LAT` cycles the FSM goes to DONE.
- DIV: one restoring step per cycle on a 64-bit {rem, quot} shift register.
  - Each step computes trial = rem_shifted − |b|.
  - If trial ≥ 0, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - After 32 steps the FSM goes to DONE.
- Sign fix for DIV only:
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder is negated if sign(a) = 1.
- Divide by zero follows the algorithm naturally: quotient magnitude 0xFFFFFFFF, remainder magnitude |a|, then the sign fix above.
- DONE: `valid_o = ~flush_i`, `stall_o = 0`; next state is IDLE unconditionally.
- `hi_o`/`lo_o` are registered. They update on entry to DONE and hold until the next DONE.
- `flush_i` in MUL, DIV or DONE forces IDLE at the next edge; no `valid_o`, and `hi_o`/`lo_o` keep their old values.
- `stall_o = resetn & ~flush_i & ((state==IDLE & start_i) | state==MUL | state==DIV)`.

## Timing
- Reset (async, `resetn=0`): state IDLE, counter 0, `hi_o=lo_o=0`, `valid_o=0`, `busy_o=0`, `stall_o=0`.
- Acceptance is in cycle T, with `stall_o=1` combinationally in T.
- MUL:
  - Cycles T+1..T+MUL_LAT are in MUL.
  - DONE is at T+MUL_LAT+1.
- DIV:
  - Cycles T+1..T+32 are in DIV.
  - DONE is at T+33.
- DONE cycle: the pipeline advances. `start_i` seen in the following IDLE cycle belongs to the next instruction.
  - Back-to-back ops therefore have one idle cycle between them; minimum issue interval is latency+1.
- A `start_i` in DONE is ignored; the request is re-evaluated in IDLE.
- Flush and start in the same IDLE cycle: the request is not accepted and `stall_o=0`.
- Operand changes after acceptance have no effect.

## Configuration
- `MULDIV_DIV0_FAST_EN` defined:
  - A DIV/DIVU with `src_b_i==0` goes IDLE → DONE directly, at T+1.
  - Results are bit-identical to the iterative path (see Operation).
- Undefined: divide-by-zero runs the full 32 DIV cycles.

## Test plan
- MULT, a=0xFFFFFFFF, b=0x00000002, MUL_LAT=2 -> `valid_o` at T+3, hi=0xFFFFFFFF, lo=0xFFFFFFFE; `stall_o` high T..T+2.
- MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIVU, a=100, b=7 -> `valid_o` at T+33, lo=0x0000000E, hi=0x00000002; DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, a=0x80000000, b=0 -> lo=0x00000001, hi=0x80000000:
  - with the macro, valid at T+1;
  - without it, valid at T+33.
- DIV started, `flush_i` pulsed at T+10 -> IDLE at T+11, no `valid_o`, hi/lo unchanged; a new DIVU accepted at T+11 completes at T+44 correctly.
- `resetn` asserted mid-DIV -> all outputs 0 immediately; after release, MULTU 3×5 -> lo=15, hi=0.
